// File: rtl/bus_arbiter2_pkg.sv
// Shared state encoding and reset constants for the two-way round-robin bus arbiter.
// Holds no logic; the arbiter modules import it.
package bus_arbiter2_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  // Requester 0 wins the first tie after reset because last starts at 1.
  localparam logic LAST_RST = 1'b1;

endpackage

// File: rtl/bus_arbiter2_if.sv
// Requester and consumer signals of the arbiter. The slave side is the arbiter;
// the master side is whatever drives the requests and consumes out_data.
interface bus_arbiter2_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic             req0;
  logic [WIDTH-1:0] data0;
  logic             grant0;
  logic             req1;
  logic [WIDTH-1:0] data1;
  logic             grant1;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_sel;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;

  modport slave (
    input  req0, data0, req1, data1, out_ready,
    output grant0, grant1, out_valid, out_data, out_sel, cnt0, cnt1
  );

  modport master (
    output req0, data0, req1, data1, out_ready,
    input  grant0, grant1, out_valid, out_data, out_sel, cnt0, cnt1
  );
endinterface

// File: rtl/bus_arbiter2_rr2.sv
// Combinational two-way round-robin picker: alternates on a tie, otherwise grants the lone requester.
// No latency; en=0 suppresses both grants (this is how the caller applies backpressure).
module arb_rr2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  input  logic en,
  output logic grant0,
  output logic grant1,
  output logic pick
);

  always_comb begin
    pick = 1'b0;
    if (req0 && req1) begin
      pick = ~last;
    end else if (req1) begin
      pick = 1'b1;
    end
    grant0 = en & req0 & ~pick;
    grant1 = en & req1 & pick;
  end

endmodule

// File: rtl/bus_arbiter2.sv
// Round-robin 2:1 arbiter with a registered output word and saturating per-requester counters.
// Latency: 1 cycle from grant to out_valid. Backpressure: with out_ready=0 in HOLD, no grants are issued.
module bus_arbiter2
  import bus_arbiter2_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  bus_arbiter2_if.slave        bus
);

  state_t           state;
  state_t           state_nxt;
  logic             last;
  logic [WIDTH-1:0] data_q;
  logic             sel_q;
  logic [CNT_W-1:0] cnt0_q;
  logic [CNT_W-1:0] cnt1_q;
  logic             can_load;
  logic             en;
  logic             g0;
  logic             g1;
  logic             pick;
  logic             take;

  // The slot is free when it is empty or is being drained on this same edge.
  assign can_load = (state == ST_IDLE) | bus.out_ready;
  assign en       = can_load & ~rst;
  assign take     = g0 | g1;

  arb_rr2 u_rr (
    .req0   (bus.req0),
    .req1   (bus.req1),
    .last   (last),
    .en     (en),
    .grant0 (g0),
    .grant1 (g1),
    .pick   (pick)
  );

  always_comb begin
    state_nxt = state;
    if (take) begin
      state_nxt = ST_HOLD;
    end else if (state == ST_HOLD && bus.out_ready) begin
      state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      sel_q  <= 1'b0;
      last   <= LAST_RST;
    end else if (take) begin
      data_q <= pick ? bus.data1 : bus.data0;
      sel_q  <= pick;
      last   <= pick;
    end
  end

  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (g0 && !(&cnt0_q)) cnt0_q <= cnt0_q + 1'b1;
      if (g1 && !(&cnt1_q)) cnt1_q <= cnt1_q + 1'b1;
    end
  end

  assign bus.grant0    = g0;
  assign bus.grant1    = g1;
  assign bus.out_valid = (state == ST_HOLD);
  assign bus.out_data  = data_q;
  assign bus.out_sel   = sel_q;
  assign bus.cnt0      = cnt0_q;
  assign bus.cnt1      = cnt1_q;

endmodule

// File: tb/tb_bus_arbiter2.sv
// Bench for bus_arbiter2: directed scenarios with literal expectations plus a
// per-cycle reference model and word scoreboard checked on every falling edge.
module tb_bus_arbiter2;

  localparam int W  = 32;
  localparam int CW = 4;

  typedef struct packed {
    logic         sel;
    logic [W-1:0] data;
  } item_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  bus_arbiter2_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  bus_arbiter2 #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Reference model: one registered word slot, last-winner memory, saturating counts.
  logic         m_valid;
  logic [W-1:0] m_data;
  logic         m_sel;
  logic         m_last;
  int           m_cnt0;
  int           m_cnt1;
  logic         took0;
  logic         took1;
  item_t        sb[$];
  item_t        front;

  always @(negedge clk) begin
    logic free, e0, e1, consume;
    if (rst) begin
      check("rst_grant0", bus.grant0, 0);
      check("rst_grant1", bus.grant1, 0);
      check("rst_valid", bus.out_valid, 0);
      check("rst_data", bus.out_data, 0);
      check("rst_cnt0", bus.cnt0, 0);
      check("rst_cnt1", bus.cnt1, 0);
      m_valid = 1'b0; m_data = '0; m_sel = 1'b0; m_last = 1'b1;
      m_cnt0 = 0; m_cnt1 = 0; took0 = 1'b0; took1 = 1'b0;
      sb.delete();
    end else begin
      free = !m_valid || bus.out_ready;
      e0 = free && bus.req0;
      e1 = free && bus.req1;
      if (e0 && e1) begin
        // Contention goes to whoever did not win the previous grant.
        e0 = (m_last == 1'b1);
        e1 = !e0;
      end
      if (bus.grant0 && bus.grant1) check("one_hot", 2'b11, 2'b01);
      check("grant0", bus.grant0, e0);
      check("grant1", bus.grant1, e1);
      check("out_valid", bus.out_valid, m_valid);
      check("out_data", bus.out_data, m_data);
      check("out_sel", bus.out_sel, m_sel);
      check("cnt0", bus.cnt0, m_cnt0);
      check("cnt1", bus.cnt1, m_cnt1);
      consume = m_valid && bus.out_ready;
      if (consume) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 1, 0);
        end else begin
          front = sb.pop_front();
          check("sb_data", bus.out_data, front.data);
          check("sb_sel", bus.out_sel, front.sel);
        end
        m_valid = 1'b0;
      end
      if (e0 || e1) begin
        m_valid = 1'b1;
        m_sel   = e1;
        m_data  = e1 ? bus.data1 : bus.data0;
        m_last  = e1;
        sb.push_back('{sel: e1, data: m_data});
        if (e0) m_cnt0 = (m_cnt0 >= (1 << CW) - 1) ? m_cnt0 : m_cnt0 + 1;
        if (e1) m_cnt1 = (m_cnt1 >= (1 << CW) - 1) ? m_cnt1 : m_cnt1 + 1;
      end
      took0 = e0;
      took1 = e1;
    end
  end

  initial begin
    int seq[4];
    total = 0;
    bad   = 0;
    rst = 1'b1;
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.data0 = '0; bus.data1 = '0; bus.out_ready = 1'b0;
    #1;
    check("init_valid", bus.out_valid, 0);
    check("init_sel", bus.out_sel, 0);
    tick();
    tick();
    rst = 1'b0;

    // Async reset while holding a word
    bus.req0 = 1'b1; bus.data0 = 32'hDEAD_BEEF; bus.out_ready = 1'b0;
    tick();
    bus.req0 = 1'b0;
    #1;
    check("t1_hold_data", bus.out_data, 32'hDEAD_BEEF);
    check("t1_hold_valid", bus.out_valid, 1);
    check("t1_hold_cnt0", bus.cnt0, 1);
    rst = 1'b1;
    bus.req0 = 1'b1;
    #1;
    check("t1_async_valid", bus.out_valid, 0);
    check("t1_async_data", bus.out_data, 0);
    check("t1_async_cnt0", bus.cnt0, 0);
    check("t1_async_grant0", bus.grant0, 0);
    tick();
    rst = 1'b0;
    bus.req0 = 1'b0;

    // Both requesting with a always-ready consumer: strict alternation from requester 0
    seq = '{5, 7, 5, 7};
    bus.req0 = 1'b1; bus.req1 = 1'b1; bus.data0 = 5; bus.data1 = 7; bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      #1;
      check("t2_data", bus.out_data, seq[i]);
      check("t2_valid", bus.out_valid, 1);
    end
    check("t2_cnt0", bus.cnt0, 2);
    check("t2_cnt1", bus.cnt1, 2);
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    tick();
    #1;
    check("t2_drain", bus.out_valid, 0);

    // Lone requester 1 against a stalled consumer
    bus.out_ready = 1'b0; bus.req1 = 1'b1; bus.data1 = 12;
    #1;
    check("t3_grant1", bus.grant1, 1);
    tick();
    #1;
    for (int k = 0; k < 3; k++) begin
      check("t3_no_grant", bus.grant1, 0);
      check("t3_data", bus.out_data, 12);
      check("t3_sel", bus.out_sel, 1);
      tick();
      #1;
    end

    // Release the stall with requester 1 withdrawn
    bus.req1 = 1'b0; bus.out_ready = 1'b1;
    #1;
    check("t4_valid_before", bus.out_valid, 1);
    tick();
    #1;
    check("t4_valid_after", bus.out_valid, 0);
    check("t4_data_kept", bus.out_data, 12);
    check("t4_cnt1", bus.cnt1, 3);

    // Counter saturation
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.req0 = 1'b1; bus.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.data0 = 100 + i;
      tick();
      if (i == 13) check("t5_cnt0_14", bus.cnt0, 14);
    end
    #1;
    check("t5_cnt0_sat", bus.cnt0, 15);
    check("t5_cnt1", bus.cnt1, 0);
    check("t5_last_word", bus.out_data, 119);
    bus.req0 = 1'b0;
    tick();

    // Random traffic honouring the hold-until-granted rule
    for (int c = 0; c < 10000; c++) begin
      rst = ((c % 2500) == 1234);
      if (bus.req0 && !took0) begin
        if ($urandom_range(0, 7) == 0) bus.req0 = 1'b0;
      end else begin
        bus.req0  = $urandom_range(0, 1);
        bus.data0 = $urandom;
      end
      if (bus.req1 && !took1) begin
        if ($urandom_range(0, 7) == 0) bus.req1 = 1'b0;
      end else begin
        bus.req1  = $urandom_range(0, 1);
        bus.data1 = $urandom;
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    rst = 1'b0;
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.out_ready = 1'b0;
    tick();
    #1;
    check("sb_level", sb.size(), bus.out_valid);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
